// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma symbol, receive FSM encoding and lock depth.
package phy_pkg;

  localparam logic [7:0] COM             = 8'hBC;
  localparam int         BC_LOCK_DEFAULT = 4;
  localparam int         DATA_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    RX_UNLOCKED = 2'd0,
    RX_ALIGNING = 2'd1,
    RX_ACTIVE   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_deserializer.sv
// Receive lane deserializer: bit-granular COM search, byte alignment lock,
// then aligned byte delivery with a valid flag and a boundary strobe.
module phy_rx_deserializer
  import phy_pkg::*;
#(
  parameter int BC_LOCK = BC_LOCK_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic              clk32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_strobe,
  output logic              active
);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] byte_next;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [3:0]        bc_cnt, bc_cnt_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              strobe_d;
  logic              is_com;
  logic              boundary;

  assign byte_next = {shift_reg[DATA_W-2:0], data_in};
  assign is_com    = (byte_next == COM);
  assign boundary  = (bit_cnt == 3'd7);
  assign active    = (state_q == RX_ACTIVE);

  // Next-state, counter and output decode for the alignment FSM.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt;
    bc_cnt_d  = bc_cnt;
    data_d    = data_out;
    valid_d   = valid_out;
    strobe_d  = 1'b0;
    unique case (state_q)
      RX_UNLOCKED: begin
        // Counter stays parked so the first aligned byte starts at bit 0.
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
        valid_d   = 1'b0;
        if (is_com) begin
          bc_cnt_d = 4'd1;
          state_d  = (BC_LOCK == 1) ? RX_ACTIVE : RX_ALIGNING;
        end
      end
      RX_ALIGNING: begin
        bit_cnt_d = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_com) begin
            bc_cnt_d = bc_cnt + 4'd1;
            if ((bc_cnt + 4'd1) == 4'(BC_LOCK)) begin
              state_d = RX_ACTIVE;
            end
          end else begin
            // Alignment broken: drop this byte and resume the bit search.
            state_d   = RX_UNLOCKED;
            bc_cnt_d  = 4'd0;
            bit_cnt_d = 3'd0;
          end
        end
      end
      RX_ACTIVE: begin
        bit_cnt_d = bit_cnt + 3'd1;
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
          end else begin
            data_d  = byte_next;
            valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = RX_UNLOCKED;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = 4'd0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State, counters, shifter and registered outputs; async clear on reset.
  always_ff @(posedge clk32f or posedge reset) begin
    if (reset) begin
      state_q     <= RX_UNLOCKED;
      shift_reg   <= '0;
      bit_cnt     <= 3'd0;
      bc_cnt      <= 4'd0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg   <= byte_next;
      bit_cnt     <= bit_cnt_d;
      bc_cnt      <= bc_cnt_d;
      data_out    <= data_d;
      valid_out   <= valid_d;
      byte_strobe <= strobe_d;
    end
  end

endmodule
